// File: rtl/checker_pkg.sv
// ---------------------------------------------------------------------------
// checker_pkg
// Shared definitions for the checker line arbiter slice:
//   state_t  - arbiter FSM states
//   CH_*     - character constants seen by the character checker
//   res_t    - per-line result record {src, format, error, abort}
// ---------------------------------------------------------------------------
package checker_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_STREAM  = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_ABORT   = 3'd4
   } state_t;

   localparam logic [7:0] CH_CARET = 8'h5E;  // '^'
   localparam logic [7:0] CH_HASH  = 8'h23;  // '#'
   localparam logic [7:0] CH_FILL  = 8'h20;  // idle filler, never '^'

   // Source id is held at a fixed 8-bit width so the record does not depend
   // on the arbiter's ID_W parameter.
   typedef struct packed {
      logic [7:0] src;
      logic [1:0] format;
      logic [3:0] error;
      logic       abort;
   } res_t;

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin priority encoder. Searches i_valid starting at
// the index after i_last and wrapping modulo N_SRC; i_last itself is checked
// last.
//   i_valid [N_SRC] - request vector
//   i_last  [ID_W]  - most recent grant
//   o_found         - at least one request present
//   o_idx   [ID_W]  - chosen index (0 when nothing found)
// ---------------------------------------------------------------------------
module rr_picker #(
   parameter int unsigned N_SRC = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic [N_SRC-1:0] i_valid,
   input  logic [ID_W-1:0]  i_last,
   output logic             o_found,
   output logic [ID_W-1:0]  o_idx
);

   int unsigned     w_cand;
   logic [ID_W-1:0] w_idx;

   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_cand  = 0;
      w_idx   = '0;
      for (int unsigned k = 1; k <= N_SRC; k++) begin
         w_cand = (32'(i_last) + k) % N_SRC;
         w_idx  = ID_W'(w_cand);
         if (!o_found && i_valid[w_idx]) begin
            o_found = 1'b1;
            o_idx   = w_idx;
         end
      end
   end

endmodule

// File: rtl/checker_line_arbiter.sv
// ---------------------------------------------------------------------------
// checker_line_arbiter
// Shares one character checker between N_SRC trace sources. A source is
// granted for a complete line (through '#'); its chars are forwarded one per
// clock, the checker's verdict is captured two cycles after '#', and the
// result is returned tagged with the source id. A gap in the granted source
// or an over-long line aborts the line and resets the checker.
//   clk, reset           - clock, synchronous active-high reset
//   req_valid/req_char   - per-source char offer (source i at [8i+7:8i])
//   req_ready            - one-hot consume strobe for the granted source
//   chk_char/chk_reset   - drive to the checker
//   chk_format_type/
//   chk_error_code       - checker verdict, sampled in CAPTURE
//   res_*                - one-cycle result pulse, fields hold until next
//   busy                 - arbiter not idle
// ---------------------------------------------------------------------------
module checker_line_arbiter
   import checker_pkg::*;
#(
   parameter int unsigned N_SRC     = 4,
   parameter int unsigned ID_W      = 2,
   parameter int unsigned MAX_LEN   = 64,
   parameter logic [7:0]  FILL_CHAR = CH_FILL
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_SRC-1:0]     req_valid,
   input  logic [8*N_SRC-1:0]   req_char,
   output logic [N_SRC-1:0]     req_ready,
   output logic [7:0]           chk_char,
   output logic                 chk_reset,
   input  logic [1:0]           chk_format_type,
   input  logic [3:0]           chk_error_code,
   output logic                 res_valid,
   output logic [ID_W-1:0]      res_src,
   output logic [1:0]           res_format,
   output logic [3:0]           res_error,
   output logic                 res_abort,
   output logic                 busy
);

   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

   state_t           r_state;
   // The current grant doubles as the round-robin pointer: the next search
   // starts just after whichever source was served last.
   logic [ID_W-1:0]  r_grant;
   logic [LEN_W-1:0] r_len;
   logic [7:0]       r_chk_char;
   logic             r_res_valid;
   logic [ID_W-1:0]  r_res_src;
   logic [1:0]       r_res_format;
   logic [3:0]       r_res_error;
   logic             r_res_abort;

   logic             w_found;
   logic [ID_W-1:0]  w_pick;
   logic             w_sel_valid;
   logic [7:0]       w_sel_char;
   logic [LEN_W-1:0] w_len_inc;

   rr_picker #(
      .N_SRC (N_SRC),
      .ID_W  (ID_W)
   ) u_pick (
      .i_valid (req_valid),
      .i_last  (r_grant),
      .o_found (w_found),
      .o_idx   (w_pick)
   );

   assign w_sel_valid = req_valid[r_grant];
   assign w_sel_char  = req_char[{r_grant, 3'b000} +: 8];
   assign w_len_inc   = r_len + LEN_W'(1);

   assign req_ready  = (r_state == ST_STREAM) ? (N_SRC'(1) << r_grant) : '0;
   assign chk_char   = r_chk_char;
   assign chk_reset  = reset || (r_state == ST_ABORT);
   assign res_valid  = r_res_valid;
   assign res_src    = r_res_src;
   assign res_format = r_res_format;
   assign res_error  = r_res_error;
   assign res_abort  = r_res_abort;
   assign busy       = (r_state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_grant      <= ID_W'(N_SRC - 1);
         r_len        <= '0;
         r_chk_char   <= FILL_CHAR;
         r_res_valid  <= 1'b0;
         r_res_src    <= '0;
         r_res_format <= '0;
         r_res_error  <= '0;
         r_res_abort  <= 1'b0;
      end else begin
         r_res_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_chk_char <= FILL_CHAR;
               if (w_found) begin
                  r_grant <= w_pick;
                  r_state <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (w_sel_valid) begin
                  r_chk_char <= w_sel_char;
                  r_len      <= w_len_inc;
                  if (w_sel_char == CH_HASH)
                     r_state <= ST_WAIT;
                  else if (w_len_inc == LEN_W'(MAX_LEN))
                     r_state <= ST_ABORT;
               end else begin
                  // Underflow: the checker cannot tolerate a gap mid-line.
                  r_chk_char <= FILL_CHAR;
                  r_state    <= ST_ABORT;
               end
            end
            ST_WAIT: begin
               r_chk_char <= FILL_CHAR;
               r_state    <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               r_chk_char   <= FILL_CHAR;
               r_res_valid  <= 1'b1;
               r_res_src    <= r_grant;
               r_res_format <= chk_format_type;
               r_res_error  <= chk_error_code;
               r_res_abort  <= 1'b0;
               r_len        <= '0;
               r_state      <= ST_IDLE;
            end
            ST_ABORT: begin
               r_chk_char   <= FILL_CHAR;
               r_res_valid  <= 1'b1;
               r_res_src    <= r_grant;
               r_res_format <= '0;
               r_res_error  <= '0;
               r_res_abort  <= 1'b1;
               r_len        <= '0;
               r_state      <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/checker_line_arbiter.md
Name: checker_line_arbiter

Overview:
- Shares one cpu_checker_chall-style character checker between N_SRC trace sources.
- Grants one source for a whole output line (from first char through '#'), round-robin between lines.
- Forwards that source's chars to the checker one per clock, captures the checker's format/error verdict, and returns it tagged with the source id.
- The checker consumes a char every edge and has no valid input. This block therefore guarantees an uninterrupted line, or aborts the line and resets the checker.

Parameters:
- N_SRC, 4, number of requesting trace sources.
- ID_W, 2, source id width, equal to clog2(N_SRC).
- MAX_LEN, 64, maximum forwarded chars per line before abort.
- FILL_CHAR, 8'h20, char driven to the checker when no line is active (never '^').

Ports:
- clk  in  1  clock.
- reset  in  1  sync active-high reset.
- req_valid  in  N_SRC  source i has a char on req_char[i].
- req_char  in  8*N_SRC  packed chars; source i at [8i+7:8i].
- req_ready  out  N_SRC  one-hot or zero; a char from source i is consumed when valid&ready.
- chk_char  out  8  registered char to the checker.
- chk_reset  out  1  reset to the checker.
- chk_format_type  in  2  checker verdict format.
- chk_error_code  in  4  checker verdict error.
- res_valid  out  1  one-cycle result pulse.
- res_src  out  ID_W  source id of the result.
- res_format  out  2  captured format_type.
- res_error  out  4  captured error_code.
- res_abort  out  1  line aborted; format/error are 0.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset state:
  - state IDLE; chk_char = FILL_CHAR; chk_reset = 1 while reset is high.
  - req_ready = 0; res_* = 0; busy = 0.
  - RR pointer = N_SRC-1, so source 0 wins first. Length counter = 0.
- FSM states: IDLE, STREAM, WAIT, CAPTURE, ABORT.
- IDLE:
  - chk_char <= FILL_CHAR.
  - If any req_valid: grant <= first valid index after the RR pointer (modulo N_SRC), RR pointer <= grant, go to STREAM.
  - No char is consumed in IDLE.
- STREAM:
  - req_ready[grant] = 1 combinationally; all other ready bits are 0.
  - If req_valid[grant]: chk_char <= req_char[grant], len <= len+1.
  - If that char == '#', go to WAIT.
  - Else if len+1 == MAX_LEN, go to ABORT.
  - If !req_valid[grant] (underflow): chk_char <= FILL_CHAR, go to ABORT. A gap would corrupt the checker parse.
- WAIT:
  - chk_char <= FILL_CHAR.
  - The checker sees '#' this cycle and enters its terminal state at the next edge.
  - Go to CAPTURE.
- CAPTURE:
  - chk_format_type and chk_error_code are valid this cycle.
  - Register them into res_format and res_error; res_src <= grant; res_abort <= 0; res_valid <= 1 for the next cycle.
  - len <= 0; go to IDLE.
- ABORT:
  - chk_reset = 1 for exactly one cycle; chk_char <= FILL_CHAR.
  - res_valid <= 1 next cycle with res_abort = 1, format = 0, error = 0, res_src = grant.
  - len <= 0; go to IDLE.
- Timing:
  - If '#' is on chk_char in cycle t, res_valid is high in cycle t+2.
  - The earliest next-line char reaches chk_char in cycle t+4 (IDLE grant, then STREAM).
  - At least 2 FILL cycles separate lines.
- res_valid is high for exactly one cycle per line; res_* hold their values until the next result.
- Fairness: after serving source k, sources k+1..N_SRC-1, 0..k are searched in that order. A continuously requesting source cannot win twice while another source is valid.
- '^' inside a line is forwarded unchanged; the checker resynchronises itself and the line still ends at '#'.
- A req_valid change on a non-granted source mid-line has no effect.
- Reset mid-line: immediate return to IDLE, no result emitted; the checker is reset by chk_reset = reset.

Decomposition:
- Shared package checker_pkg:
  - state enum;
  - char constants CH_CARET = "^", CH_HASH = "#", CH_FILL = FILL_CHAR;
  - result struct {src, format, error, abort}.
- One sub-module, rr_picker (N_SRC, ID_W): combinational round-robin priority encoder. Inputs are the valid vector and the last-grant pointer; outputs are the found flag and the index.

Test Plan:
- Single line from src 2, "^1234@00003000: $5 <= 0000abcd#" with the checker attached -> res_valid 2 cycles after '#' on chk_char; res_src 2, res_format 1, res_error 0, res_abort 0.
- src 0 and src 1 both continuously valid with 3 lines each -> grants alternate 0,1,0,1,0,1; lines never interleave on chk_char.
- src 3 drops req_valid after 10 chars -> next chk_char is 8'h20; chk_reset pulses for 1 cycle; res_abort 1, res_src 3, format/error 0.
- src 1 sends 64 chars with no '#' (MAX_LEN 64) -> abort after the 64th char; res_abort 1; src 1 can be granted again next.
- reset asserted mid-STREAM -> next cycle busy 0, req_ready 0, chk_char 8'h20, no res_valid; the next grant goes to the lowest valid source starting at 0.
- Line with PC 00002000 -> res_error 4'b0010 is captured from the checker; the arbiter passes the verdict through unmodified.
